// File: rtl/dac_tx.sv
// Serial transmitter for a 12-bit SPI-style DAC (16-bit frame on SYNC/SCLK/DIN).
// Frames a parallel sample, shifts it out MSB first, and reports busy/done for pacing.
module dac_tx #(
  parameter int         CLK_DIV = 4,
  parameter logic [1:0] PD_MODE = 2'b00
) (
  input  logic        clk_Nexys,
  input  logic        reset,
  input  logic        tx_start,
  input  logic [11:0] data_in,
  output logic        tx_busy,
  output logic        tx_done_tick,
  output logic        DACsync,
  output logic        DACclk,
  output logic        DACdata
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      r_state;
  logic [7:0]  r_div;
  logic [3:0]  r_bitCnt;
  logic [14:0] r_shift;

  logic [15:0] w_frame;
  logic        w_divLast;

  assign w_frame   = {2'b00, PD_MODE, data_in};
  assign w_divLast = (r_div == DIV_LAST);

  // r_shift holds only the bits still to be sent; frame[15] goes straight to DACdata.
  always_ff @(posedge clk_Nexys or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_div        <= '0;
      r_bitCnt     <= '0;
      r_shift      <= '0;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
      DACsync      <= 1'b1;
      DACclk       <= 1'b1;
      DACdata      <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      case (r_state)
        IDLE: begin
          DACsync <= 1'b1;
          DACclk  <= 1'b1;
          if (tx_start) begin
            r_shift  <= w_frame[14:0];
            DACsync  <= 1'b0;
            DACdata  <= w_frame[15];
            r_bitCnt <= 4'd15;
            r_div    <= '0;
            tx_busy  <= 1'b1;
            r_state  <= SHIFT;
          end
        end

        SHIFT: begin
          if (w_divLast) begin
            r_div <= '0;
            if (DACclk) begin
              DACclk <= 1'b0;
            end else if (r_bitCnt != 4'd0) begin
              // Data only moves on the rising edge so it is stable across the next fall.
              DACclk   <= 1'b1;
              DACdata  <= r_shift[14];
              r_shift  <= {r_shift[13:0], 1'b0};
              r_bitCnt <= r_bitCnt - 4'd1;
            end else begin
              DACclk       <= 1'b1;
              DACsync      <= 1'b1;
              DACdata      <= 1'b0;
              tx_done_tick <= 1'b1;
              r_state      <= GAP;
            end
          end else begin
            r_div <= r_div + 8'd1;
          end
        end

        GAP: begin
          if (w_divLast) begin
            r_div   <= '0;
            tx_busy <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_div <= r_div + 8'd1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_tx.sv
// Self-checking bench for dac_tx: a bus monitor captures serial frames and a
// scoreboard compares them against words pushed when each frame is requested.
module tb_dac_tx;

  localparam int CD = 4;

  logic             clk_Nexys = 1'b0;
  logic             reset     = 1'b1;
  logic [1:0]       txStart   = '0;
  logic [1:0][11:0] dataIn    = '0;
  wire  [1:0]       txBusy;
  wire  [1:0]       txDone;
  wire  [1:0]       dacSync;
  wire  [1:0]       dacClk;
  wire  [1:0]       dacData;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          inst;
    logic [15:0] word;
  } exp_t;

  typedef struct {
    logic [15:0] word;
    int          bits;
  } cap_t;

  typedef struct {
    int          inst;
    logic [11:0] data;
    logic [15:0] expWord;
    int          injectAt;
  } vec_t;

  exp_t expQ[$];
  cap_t capQ0[$];
  cap_t capQ1[$];

  bit          active[2]   = '{1'b0, 1'b0};
  bit          prevSync[2] = '{1'b1, 1'b1};
  bit          prevClk[2]  = '{1'b1, 1'b1};
  int          bitCnt[2]   = '{0, 0};
  int          clkViol[2]  = '{0, 0};
  logic [15:0] acc[2]      = '{16'h0, 16'h0};

  dac_tx #(.CLK_DIV(CD), .PD_MODE(2'b00)) u_dac (
    .clk_Nexys   (clk_Nexys),
    .reset       (reset),
    .tx_start    (txStart[0]),
    .data_in     (dataIn[0]),
    .tx_busy     (txBusy[0]),
    .tx_done_tick(txDone[0]),
    .DACsync     (dacSync[0]),
    .DACclk      (dacClk[0]),
    .DACdata     (dacData[0])
  );

  dac_tx #(.CLK_DIV(CD), .PD_MODE(2'b11)) u_dacPd (
    .clk_Nexys   (clk_Nexys),
    .reset       (reset),
    .tx_start    (txStart[1]),
    .data_in     (dataIn[1]),
    .tx_busy     (txBusy[1]),
    .tx_done_tick(txDone[1]),
    .DACsync     (dacSync[1]),
    .DACclk      (dacClk[1]),
    .DACdata     (dacData[1])
  );

  always #5 clk_Nexys = ~clk_Nexys;

  // Acts like the DAC: shifts in DACdata on every falling DACclk while SYNC is low.
  always @(negedge clk_Nexys) begin
    for (int g = 0; g < 2; g++) begin
      if (reset) begin
        active[g] = 1'b0;
        bitCnt[g] = 0;
        acc[g]    = '0;
      end else begin
        if (prevSync[g] && !dacSync[g]) begin
          active[g] = 1'b1;
          bitCnt[g] = 0;
          acc[g]    = '0;
        end
        if (active[g] && !dacSync[g] && prevClk[g] && !dacClk[g]) begin
          acc[g] = {acc[g][14:0], dacData[g]};
          bitCnt[g]++;
        end
        if (prevSync[g] && dacSync[g] && (prevClk[g] != dacClk[g]))
          clkViol[g]++;
        if (active[g] && !prevSync[g] && dacSync[g]) begin
          if (g == 0) capQ0.push_back('{acc[g], bitCnt[g]});
          else        capQ1.push_back('{acc[g], bitCnt[g]});
          active[g] = 1'b0;
        end
      end
      prevSync[g] = dacSync[g];
      prevClk[g]  = dacClk[g];
    end
  end

  task automatic checkValue(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Sends one frame and checks the done pulse and busy release timing against E.
  task automatic applyStimulus(input int inst, input logic [11:0] d,
                               input logic [15:0] expWord, input int injectAt);
    int doneCycle = -1;
    int doneCount = 0;
    int busyFall  = -1;
    @(negedge clk_Nexys);
    dataIn[inst]  = d;
    txStart[inst] = 1'b1;
    expQ.push_back('{inst, expWord});
    @(posedge clk_Nexys);
    #1;
    checkValue("busyAtAccept", txBusy[inst], 1);
    checkValue("syncLowAtAccept", dacSync[inst], 0);
    txStart[inst] = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk_Nexys);
      #1;
      txStart[inst] = 1'b0;
      if (k == injectAt) begin
        txStart[inst] = 1'b1;
        dataIn[inst]  = 12'h555;
      end
      if (txDone[inst]) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = k;
      end
      if (!txBusy[inst]) begin
        busyFall = k;
        break;
      end
    end
    checkValue("doneTickCycle", doneCycle, 32 * CD);
    checkValue("doneTickCount", doneCount, 1);
    checkValue("busyFallCycle", busyFall, 33 * CD);
  endtask

  task automatic checkOutput();
    exp_t e;
    cap_t c;
    bit   have;
    checkValue("expectedPending", expQ.size() > 0, 1);
    if (expQ.size() > 0) begin
      e    = expQ.pop_front();
      have = (e.inst == 0) ? (capQ0.size() > 0) : (capQ1.size() > 0);
      checkValue("framePresent", have, 1);
      if (have) begin
        c = (e.inst == 0) ? capQ0.pop_front() : capQ1.pop_front();
        checkValue("frameWord", c.word, e.word);
        checkValue("frameBits", c.bits, 16);
      end
    end
  endtask

  vec_t vecs[6];

  initial begin
    int acceptN;
    int ticks;
    int gap;
    int k1;
    int k2;
    int bad;
    bit prevBusy;

    vecs[0] = '{0, 12'hABC, 16'h0ABC, 0};
    vecs[1] = '{0, 12'h000, 16'h0000, 0};
    vecs[2] = '{0, 12'hFFF, 16'h0FFF, 0};
    vecs[3] = '{1, 12'h123, 16'h3123, 0};
    vecs[4] = '{1, 12'hFFF, 16'h3FFF, 0};
    vecs[5] = '{0, 12'hABC, 16'h0ABC, 40};

    repeat (3) @(posedge clk_Nexys);
    #1;
    for (int g = 0; g < 2; g++) begin
      checkValue("resetSync", dacSync[g], 1);
      checkValue("resetClk", dacClk[g], 1);
      checkValue("resetData", dacData[g], 0);
      checkValue("resetBusy", txBusy[g], 0);
      checkValue("resetDone", txDone[g], 0);
    end
    @(negedge clk_Nexys);
    reset = 1'b0;
    repeat (5) @(posedge clk_Nexys);

    $display("[TB] table vectors");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].inst, vecs[i].data, vecs[i].expWord, vecs[i].injectAt);
      checkOutput();
      repeat (3) @(posedge clk_Nexys);
    end

    $display("[TB] back-to-back frames");
    acceptN = 0; ticks = 0; gap = 0; k1 = -1; k2 = -1;
    @(negedge clk_Nexys);
    dataIn[0]  = 12'h111;
    txStart[0] = 1'b1;
    expQ.push_back('{0, 16'h0111});
    prevBusy = txBusy[0];
    for (int k = 1; k <= 500; k++) begin
      @(posedge clk_Nexys);
      #1;
      if (txBusy[0] && !prevBusy) begin
        acceptN++;
        if (acceptN == 1) begin
          k1 = k;
          dataIn[0] = 12'h222;
          expQ.push_back('{0, 16'h0222});
        end else if (acceptN == 2) begin
          k2 = k;
        end
      end
      prevBusy = txBusy[0];
      if (txDone[0]) begin
        ticks++;
        if (ticks == 2) txStart[0] = 1'b0;
      end
      if (ticks == 1 && acceptN == 1 && dacSync[0]) gap++;
      if (ticks == 2 && !txBusy[0]) break;
    end
    txStart[0] = 1'b0;
    checkValue("b2bAccepts", acceptN, 2);
    checkValue("b2bDoneTicks", ticks, 2);
    checkValue("b2bPeriod", k2 - k1, 33 * CD + 1);
    checkValue("b2bSyncGap", gap, CD + 1);
    checkOutput();
    checkOutput();
    repeat (5) @(posedge clk_Nexys);

    $display("[TB] reset mid-frame");
    @(negedge clk_Nexys);
    dataIn[0]  = 12'h3F0;
    txStart[0] = 1'b1;
    expQ.push_back('{0, 16'h03F0});
    @(posedge clk_Nexys);
    #1;
    txStart[0] = 1'b0;
    repeat (54) @(posedge clk_Nexys);
    #1;
    checkValue("preResetClkLow", dacClk[0], 0);
    reset = 1'b1;
    #1;
    checkValue("abortSync", dacSync[0], 1);
    checkValue("abortClk", dacClk[0], 1);
    checkValue("abortData", dacData[0], 0);
    checkValue("abortBusy", txBusy[0], 0);
    checkValue("abortDone", txDone[0], 0);
    @(negedge clk_Nexys);
    @(negedge clk_Nexys);
    reset = 1'b0;
    void'(expQ.pop_back());
    checkValue("abortedFrameDropped", capQ0.size(), 0);
    bad = 0;
    repeat (200) begin
      @(posedge clk_Nexys);
      #1;
      if (!dacSync[0] || !dacClk[0] || txBusy[0]) bad++;
    end
    checkValue("idleAfterReset", bad, 0);
    applyStimulus(0, 12'h3C5, 16'h03C5, 0);
    checkOutput();

    repeat (150) @(posedge clk_Nexys);
    checkValue("clkWhileSyncHigh0", clkViol[0], 0);
    checkValue("clkWhileSyncHigh1", clkViol[1], 0);
    checkValue("extraFrames0", capQ0.size(), 0);
    checkValue("extraFrames1", capQ1.size(), 0);
    checkValue("unmatchedExpected", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
